// File: rtl/calc_pkg.sv
// Shared opcode, FSM-state and width definitions for the calculator sequencer.
package calc_pkg;

  localparam int unsigned N_DEFAULT = 4;
  localparam logic [7:0] DIV0_RESULT = 8'hFF;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/calc_if.sv
// Start/busy/done handshake plus operand and result bus of the calculator sequencer.
interface calc_if
  import calc_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) ();

  logic             start;
  op_e              op;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic             busy;
  logic             done;
  logic             err;
  logic [2*N-1:0]   result;
  logic [2*N-1:0]   remainder;

  modport master (
    output start, op, a, b,
    input  busy, done, err, result, remainder
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, err, result, remainder
  );

endinterface

// File: rtl/div_step.sv
// One restoring-divide iteration: shift {A,Q} left, trial-subtract B, restore on borrow.
module div_step
  import calc_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic [N:0]   a_in,
  input  logic [N-1:0] q_in,
  input  logic [N-1:0] b,
  output logic [N:0]   a_out,
  output logic [N-1:0] q_out
);

  logic [N:0] shifted;
  logic [N:0] diff;

  // A stays below B between steps, so a_in[N] is always zero and may be dropped.
  always_comb begin
    shifted = {a_in[N-1:0], q_in[N-1]};
    diff    = shifted - {1'b0, b};
    if (diff[N]) begin
      a_out = shifted;
      q_out = {q_in[N-2:0], 1'b0};
    end else begin
      a_out = diff;
      q_out = {q_in[N-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Handshaked multi-cycle add/sub/mul/div sequencer; mul and div run one iteration per cycle.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input logic  clk,
  input logic  rst,
  calc_if.slave bus
);

  localparam int unsigned W  = 2 * N;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  state_e        state_q, state_d;
  logic          req_q, req_d;
  op_e           req_op_q, req_op_d;
  logic [N-1:0]  req_a_q, req_a_d, req_b_q, req_b_d;
  op_e           op_q, op_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [N:0]    rem_q, rem_d;
  logic [N-1:0]  quo_q, quo_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [W-1:0]  result_q, result_d, remainder_q, remainder_d;

  logic [N:0]    step_a;
  logic [N-1:0]  step_q;
  logic [W-1:0]  mul_term, acc_next;
  logic          last_iter;

  div_step #(.N(N)) u_div_step (
    .a_in  (rem_q),
    .q_in  (quo_q),
    .b     (b_q),
    .a_out (step_a),
    .q_out (step_q)
  );

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d     = state_q;
    req_d       = bus.start && !busy_q && (state_q == IDLE);
    req_op_d    = bus.op;
    req_a_d     = bus.a;
    req_b_d     = bus.b;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    result_d    = result_q;
    remainder_d = remainder_q;

    mul_term  = b_q[cnt_q] ? (W'(a_q) << cnt_q) : '0;
    acc_next  = acc_q + mul_term;
    last_iter = (cnt_q == CW'(N - 1));

    unique case (state_q)
      IDLE: begin
        if (req_q) begin
          op_d   = req_op_q;
          a_d    = req_a_q;
          b_d    = req_b_q;
          cnt_d  = '0;
          acc_d  = '0;
          rem_d  = '0;
          quo_d  = req_a_q;
          busy_d = 1'b1;
          if (req_op_q == OP_DIV && req_b_q == '0) begin
            state_d     = DONE;
            done_d      = 1'b1;
            err_d       = 1'b1;
            result_d    = W'(DIV0_RESULT);
            remainder_d = '0;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        unique case (op_q)
          OP_ADD, OP_SUB: begin
            result_d    = (op_q == OP_ADD) ? (W'(a_q) + W'(b_q)) : (W'(a_q) - W'(b_q));
            remainder_d = '0;
            err_d       = 1'b0;
            done_d      = 1'b1;
            state_d     = DONE;
          end
          OP_MUL: begin
            acc_d = acc_next;
            cnt_d = cnt_q + CW'(1);
            if (last_iter) begin
              result_d    = acc_next;
              remainder_d = '0;
              err_d       = 1'b0;
              done_d      = 1'b1;
              state_d     = DONE;
            end
          end
          OP_DIV: begin
            rem_d = step_a;
            quo_d = step_q;
            cnt_d = cnt_q + CW'(1);
            if (last_iter) begin
              result_d    = W'(step_q);
              remainder_d = W'(step_a[N-1:0]);
              err_d       = 1'b0;
              done_d      = 1'b1;
              state_d     = DONE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      req_op_q    <= OP_ADD;
      req_a_q     <= '0;
      req_b_q     <= '0;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      result_q    <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      req_op_q    <= req_op_d;
      req_a_q     <= req_a_d;
      req_b_q     <= req_b_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.result    = result_q;
  assign bus.remainder = remainder_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer; cycle k is the cycle after edge Ek.
module tb_calc_sequencer;
  import calc_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  int          fd, dc;
  logic [15:0] bh;
  logic [7:0]  rs, rm;
  logic        es;

  calc_if #(.N(4)) bus ();

  calc_sequencer #(.N(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one edge (E0); operands are scrambled afterwards.
  task automatic start_op(input op_e op, input logic [3:0] a, input logic [3:0] b);
    @(posedge clk);
    #1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.b     = ~b;
    bus.op    = OP_ADD;
  endtask

  // Sample cycles 0..ncyc-1 at the falling edge; capture outputs at the first done.
  task automatic observe(input int ncyc, output int first_done, output int done_cnt,
                         output logic [15:0] busy_hist, output logic [7:0] res_s,
                         output logic [7:0] rem_s, output logic err_s);
    first_done = -1;
    done_cnt   = 0;
    busy_hist  = '0;
    res_s      = '0;
    rem_s      = '0;
    err_s      = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      busy_hist[k] = bus.busy;
      if (bus.done) begin
        done_cnt++;
        if (first_done < 0) begin
          first_done = k;
          res_s      = bus.result;
          rem_s      = bus.remainder;
          err_s      = bus.err;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = OP_ADD;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    bus.op    = OP_MUL;
    bus.a     = 4'd3;
    bus.b     = 4'd3;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.err); end
    n_cmp++; if (bus.result !== 8'h00) begin n_fail++; $display("FAIL reset_result: got %h expected 00", bus.result); end
    n_cmp++; if (bus.remainder !== 8'h00) begin n_fail++; $display("FAIL reset_remainder: got %h expected 00", bus.remainder); end
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_dominates_start: busy got %b expected 0", bus.busy); end
  endtask

  task automatic test_div();
    start_op(OP_DIV, 4'd13, 4'd4);
    observe(12, fd, dc, bh, rs, rm, es);
    n_cmp++; if (fd !== 5) begin n_fail++; $display("FAIL div13_4_latency: got %0d expected 5", fd); end
    n_cmp++; if (dc !== 1) begin n_fail++; $display("FAIL div13_4_done_count: got %0d expected 1", dc); end
    n_cmp++; if (bh !== 16'h003E) begin n_fail++; $display("FAIL div13_4_busy: got %h expected 003e", bh); end
    n_cmp++; if (rs !== 8'h03) begin n_fail++; $display("FAIL div13_4_result: got %h expected 03", rs); end
    n_cmp++; if (rm !== 8'h01) begin n_fail++; $display("FAIL div13_4_remainder: got %h expected 01", rm); end
    n_cmp++; if (es !== 1'b0) begin n_fail++; $display("FAIL div13_4_err: got %b expected 0", es); end
    n_cmp++; if (bus.result !== 8'h03) begin n_fail++; $display("FAIL div13_4_hold: got %h expected 03", bus.result); end
  endtask

  task automatic test_div_by_zero();
    start_op(OP_DIV, 4'd9, 4'd0);
    observe(12, fd, dc, bh, rs, rm, es);
    n_cmp++; if (fd !== 1) begin n_fail++; $display("FAIL div0_latency: got %0d expected 1", fd); end
    n_cmp++; if (bh !== 16'h0002) begin n_fail++; $display("FAIL div0_busy: got %h expected 0002", bh); end
    n_cmp++; if (rs !== 8'hFF) begin n_fail++; $display("FAIL div0_result: got %h expected ff", rs); end
    n_cmp++; if (rm !== 8'h00) begin n_fail++; $display("FAIL div0_remainder: got %h expected 00", rm); end
    n_cmp++; if (es !== 1'b1) begin n_fail++; $display("FAIL div0_err: got %b expected 1", es); end
    n_cmp++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL div0_err_hold: got %b expected 1", bus.err); end
    start_op(OP_ADD, 4'd2, 4'd3);
    observe(12, fd, dc, bh, rs, rm, es);
    n_cmp++; if (fd !== 2) begin n_fail++; $display("FAIL add2_3_latency: got %0d expected 2", fd); end
    n_cmp++; if (rs !== 8'h05) begin n_fail++; $display("FAIL add2_3_result: got %h expected 05", rs); end
    n_cmp++; if (es !== 1'b0) begin n_fail++; $display("FAIL add2_3_err_clear: got %b expected 0", es); end
  endtask

  task automatic test_mul_add();
    start_op(OP_MUL, 4'd15, 4'd15);
    observe(12, fd, dc, bh, rs, rm, es);
    n_cmp++; if (fd !== 5) begin n_fail++; $display("FAIL mul15_15_latency: got %0d expected 5", fd); end
    n_cmp++; if (bh !== 16'h003E) begin n_fail++; $display("FAIL mul15_15_busy: got %h expected 003e", bh); end
    n_cmp++; if (rs !== 8'hE1) begin n_fail++; $display("FAIL mul15_15_result: got %h expected e1", rs); end
    n_cmp++; if (rm !== 8'h00) begin n_fail++; $display("FAIL mul15_15_remainder: got %h expected 00", rm); end
    start_op(OP_MUL, 4'd6, 4'd5);
    observe(12, fd, dc, bh, rs, rm, es);
    n_cmp++; if (rs !== 8'h1E) begin n_fail++; $display("FAIL mul6_5_result: got %h expected 1e", rs); end
    start_op(OP_ADD, 4'd15, 4'd15);
    observe(12, fd, dc, bh, rs, rm, es);
    n_cmp++; if (fd !== 2) begin n_fail++; $display("FAIL add15_15_latency: got %0d expected 2", fd); end
    n_cmp++; if (bh !== 16'h0006) begin n_fail++; $display("FAIL add15_15_busy: got %h expected 0006", bh); end
    n_cmp++; if (rs !== 8'h1E) begin n_fail++; $display("FAIL add15_15_result: got %h expected 1e", rs); end
  endtask

  task automatic test_sub();
    start_op(OP_SUB, 4'd3, 4'd5);
    observe(12, fd, dc, bh, rs, rm, es);
    n_cmp++; if (fd !== 2) begin n_fail++; $display("FAIL sub3_5_latency: got %0d expected 2", fd); end
    n_cmp++; if (rs !== 8'hFE) begin n_fail++; $display("FAIL sub3_5_result: got %h expected fe", rs); end
    n_cmp++; if (rm !== 8'h00) begin n_fail++; $display("FAIL sub3_5_remainder: got %h expected 00", rm); end
    start_op(OP_SUB, 4'd5, 4'd3);
    observe(12, fd, dc, bh, rs, rm, es);
    n_cmp++; if (rs !== 8'h02) begin n_fail++; $display("FAIL sub5_3_result: got %h expected 02", rs); end
  endtask

  task automatic test_busy_ignore();
    start_op(OP_DIV, 4'd15, 4'd2);
    fork
      observe(12, fd, dc, bh, rs, rm, es);
      begin
        repeat (2) @(posedge clk);
        #1;
        bus.op = OP_ADD; bus.a = 4'd1; bus.b = 4'd1; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
      end
    join
    n_cmp++; if (dc !== 1) begin n_fail++; $display("FAIL busy_ignore_done_count: got %0d expected 1", dc); end
    n_cmp++; if (fd !== 5) begin n_fail++; $display("FAIL busy_ignore_latency: got %0d expected 5", fd); end
    n_cmp++; if (bh !== 16'h003E) begin n_fail++; $display("FAIL busy_ignore_no_queue: got %h expected 003e", bh); end
    n_cmp++; if (rs !== 8'h07) begin n_fail++; $display("FAIL div15_2_result: got %h expected 07", rs); end
    n_cmp++; if (rm !== 8'h01) begin n_fail++; $display("FAIL div15_2_remainder: got %h expected 01", rm); end
  endtask

  task automatic test_reset_midop();
    start_op(OP_DIV, 4'd14, 4'd3);
    fork
      observe(12, fd, dc, bh, rs, rm, es);
      begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b expected 0", bus.done); end
        n_cmp++; if (bus.result !== 8'h00) begin n_fail++; $display("FAIL midreset_result: got %h expected 00", bus.result); end
        n_cmp++; if (bus.remainder !== 8'h00) begin n_fail++; $display("FAIL midreset_remainder: got %h expected 00", bus.remainder); end
      end
    join
    n_cmp++; if (dc !== 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d expected 0", dc); end
    n_cmp++; if (bh !== 16'h000E) begin n_fail++; $display("FAIL midreset_busy_hist: got %h expected 000e", bh); end
    start_op(OP_DIV, 4'd14, 4'd3);
    observe(12, fd, dc, bh, rs, rm, es);
    n_cmp++; if (fd !== 5) begin n_fail++; $display("FAIL div14_3_latency: got %0d expected 5", fd); end
    n_cmp++; if (rs !== 8'h04) begin n_fail++; $display("FAIL div14_3_result: got %h expected 04", rs); end
    n_cmp++; if (rm !== 8'h02) begin n_fail++; $display("FAIL div14_3_remainder: got %h expected 02", rm); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_div();
    test_div_by_zero();
    test_mul_add();
    test_sub();
    test_busy_ignore();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
